seq_bit_serializer: RTL

//  Parallel-to-serial stage that feeds the serial sequence checker's din input.

---
 rtl/seq_bit_serializer.sv | 120 ++++++++++++
 1 files changed

// File: rtl/seq_bit_serializer.sv
// rtl/seq_bit_serializer.sv - parallel-to-serial stage with one-word holding buffer
module seq_bit_serializer #(
    parameter int   DW        = 8,
    parameter int   DIV       = 1,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] s_data,
    input  logic          s_valid,
    output logic          s_ready,
    output logic          dout,
    output logic          dout_vld,
    output logic          frame_end,
    output logic          busy
);

    localparam int BW = $clog2(DW);
    localparam int VW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(DW - 1);
    localparam logic [VW-1:0] DIV_LAST = VW'(DIV - 1);

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] sreg_q, sreg_d;
    logic [DW-1:0] hold_q, hold_d;
    logic          hold_full_q, hold_full_d;
    logic [BW-1:0] bitcnt_q, bitcnt_d;
    logic [VW-1:0] divcnt_q, divcnt_d;

    logic xfer;
    logic bit_end;
    logic word_end;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            sreg_q      <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            bitcnt_q    <= '0;
            divcnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            bitcnt_q    <= bitcnt_d;
            divcnt_q    <= divcnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sreg_d      = sreg_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        bitcnt_d    = bitcnt_q;
        divcnt_d    = divcnt_q;

        xfer     = s_valid && !hold_full_q;
        bit_end  = (divcnt_q == DIV_LAST);
        word_end = bit_end && (bitcnt_q == BIT_LAST);

        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    sreg_d   = s_data;
                    bitcnt_d = '0;
                    divcnt_d = '0;
                    state_d  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bit_end) begin
                    divcnt_d = '0;
                    bitcnt_d = bitcnt_q + BW'(1);
                    sreg_d   = MSB_FIRST ? {sreg_q[DW-2:0], 1'b0} : {1'b0, sreg_q[DW-1:1]};
                end else begin
                    divcnt_d = divcnt_q + VW'(1);
                end
                // Word boundary: a held word wins over a fresh transfer so order is preserved.
                if (word_end) begin
                    bitcnt_d = '0;
                    if (hold_full_q) begin
                        sreg_d      = hold_q;
                        hold_full_d = 1'b0;
                    end else if (xfer) begin
                        sreg_d = s_data;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (xfer) begin
                    hold_d      = s_data;
                    hold_full_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        s_ready   = !hold_full_q;
        busy      = (state_q == ST_SHIFT);
        dout      = IDLE_BIT;
        dout_vld  = 1'b0;
        frame_end = 1'b0;
        if (state_q == ST_SHIFT) begin
            dout      = MSB_FIRST ? sreg_q[DW-1] : sreg_q[0];
            dout_vld  = (divcnt_q == '0);
            frame_end = word_end;
        end
    end

endmodule
